reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 15 +
 rtl/reorder_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: default index width, field widths
// and the dispatch type encodings.
package reorder_buffer_pkg;

    localparam int ROBSIZE  = 32'sd5;
    localparam int REG_BITS = 32'sd5;
    localparam int XLEN     = 32'sd32;

    typedef enum logic [1:0] {
        TYPE_REG = 2'd0,
        TYPE_BR  = 2'd1,
        TYPE_ST  = 2'd2
    } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: circular entry store with dispatch rename,
// CDB writeback, operand bypass lookup and mispredict flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_BITS = ROBSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                disp_valid,
    input  logic [1:0]          disp_type,
    input  logic [REG_BITS-1:0] disp_rd,
    output logic                full,
    output logic [ROB_BITS-1:0] disp_rob_id,
    input  logic                wb_valid,
    input  logic [ROB_BITS-1:0] wb_rob_id,
    input  logic [XLEN-1:0]     wb_value,
    input  logic                wb_mispredict,
    input  logic [XLEN-1:0]     wb_target,
    output logic                need_set_reg_dep,
    output logic [REG_BITS-1:0] set_dep_reg_id,
    output logic [ROB_BITS-1:0] set_dep_rob_id,
    output logic                need_set_reg_value,
    output logic [REG_BITS-1:0] set_value_reg_id,
    output logic [XLEN-1:0]     set_val,
    output logic [ROB_BITS-1:0] set_reg_rob_id,
    input  logic [ROB_BITS-1:0] need_rob_id1,
    input  logic [ROB_BITS-1:0] need_rob_id2,
    output logic                rob_value1_ready,
    output logic [XLEN-1:0]     rob_value1,
    output logic                rob_value2_ready,
    output logic [XLEN-1:0]     rob_value2,
    output logic                clear,
    output logic [XLEN-1:0]     clear_pc,
    output logic                store_commit,
    output logic [ROB_BITS-1:0] store_commit_rob_id
);

    localparam int                DEPTH     = 32'd1 << ROB_BITS;
    localparam logic [ROB_BITS:0] DEPTH_CNT = (ROB_BITS+1)'(DEPTH);
    localparam logic [ROB_BITS:0] CNT_ZERO  = {(ROB_BITS+1){1'b0}};
    localparam logic [ROB_BITS:0] CNT_ONE   = (ROB_BITS+1)'(1'b1);
    localparam logic [ROB_BITS-1:0] IDX_ZERO = {ROB_BITS{1'b0}};
    localparam logic [ROB_BITS-1:0] IDX_ONE  = ROB_BITS'(1'b1);

    logic                busy_r    [DEPTH];
    logic                ready_r   [DEPTH];
    logic [1:0]          type_r    [DEPTH];
    logic [REG_BITS-1:0] rd_r      [DEPTH];
    logic [XLEN-1:0]     value_r   [DEPTH];
    logic                mispred_r [DEPTH];
    logic [XLEN-1:0]     target_r  [DEPTH];

    logic [ROB_BITS-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
    logic [ROB_BITS:0]   count_r, count_nxt_s;
    logic                commit_s, clear_s, disp_acc_s, wb_acc_s;
    logic                byp1_s, byp2_s;

    assign full        = (count_r == DEPTH_CNT);
    assign disp_rob_id = tail_r;

    // Commit/flush decode; a mispredicted branch at the head squashes this cycle's dispatch and writeback
    always_comb begin
        commit_s   = rdy && (count_r != CNT_ZERO) && ready_r[head_r];
        clear_s    = 1'b0;
        if (commit_s && (type_r[head_r] == TYPE_BR) && mispred_r[head_r]) begin
            clear_s = 1'b1;
        end else begin
            clear_s = 1'b0;
        end
        disp_acc_s = disp_valid && !full && rdy && !clear_s;
        wb_acc_s   = wb_valid && rdy && busy_r[wb_rob_id] && !clear_s;
    end

    // Rename and commit side outputs
    always_comb begin
        need_set_reg_dep    = disp_acc_s && (disp_type == TYPE_REG) && (disp_rd != 5'd0);
        set_dep_reg_id      = disp_rd;
        set_dep_rob_id      = tail_r;
        need_set_reg_value  = 1'b0;
        set_value_reg_id    = {REG_BITS{1'b0}};
        set_val             = {XLEN{1'b0}};
        set_reg_rob_id      = IDX_ZERO;
        store_commit        = 1'b0;
        store_commit_rob_id = IDX_ZERO;
        clear               = clear_s;
        clear_pc            = {XLEN{1'b0}};
        if (commit_s) begin
            case (type_r[head_r])
                TYPE_REG: begin
                    if (rd_r[head_r] != 5'd0) begin
                        need_set_reg_value = 1'b1;
                        set_value_reg_id   = rd_r[head_r];
                        set_val            = value_r[head_r];
                        set_reg_rob_id     = head_r;
                    end else begin
                        need_set_reg_value = 1'b0;
                    end
                end
                TYPE_ST: begin
                    store_commit        = 1'b1;
                    store_commit_rob_id = head_r;
                end
                TYPE_BR: begin
                    if (clear_s) begin
                        clear_pc = target_r[head_r];
                    end else begin
                        clear_pc = {XLEN{1'b0}};
                    end
                end
                default: begin
                    need_set_reg_value = 1'b0;
                end
            endcase
        end else begin
            need_set_reg_value = 1'b0;
        end
    end

    // Operand lookup with same-cycle CDB bypass; idle entries never report ready
    always_comb begin
        byp1_s           = wb_valid && (wb_rob_id == need_rob_id1) && busy_r[need_rob_id1];
        byp2_s           = wb_valid && (wb_rob_id == need_rob_id2) && busy_r[need_rob_id2];
        rob_value1_ready = byp1_s || (busy_r[need_rob_id1] && ready_r[need_rob_id1]);
        rob_value2_ready = byp2_s || (busy_r[need_rob_id2] && ready_r[need_rob_id2]);
        rob_value1       = {XLEN{1'b0}};
        rob_value2       = {XLEN{1'b0}};
        if (byp1_s) begin
            rob_value1 = wb_value;
        end else if (rob_value1_ready) begin
            rob_value1 = value_r[need_rob_id1];
        end else begin
            rob_value1 = {XLEN{1'b0}};
        end
        if (byp2_s) begin
            rob_value2 = wb_value;
        end else if (rob_value2_ready) begin
            rob_value2 = value_r[need_rob_id2];
        end else begin
            rob_value2 = {XLEN{1'b0}};
        end
    end

    // Pointer and occupancy next-state
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (clear_s) begin
            head_nxt_s  = IDX_ZERO;
            tail_nxt_s  = IDX_ZERO;
            count_nxt_s = CNT_ZERO;
        end else begin
            if (disp_acc_s) tail_nxt_s = tail_r + IDX_ONE;
            else            tail_nxt_s = tail_r;
            if (commit_s)   head_nxt_s = head_r + IDX_ONE;
            else            head_nxt_s = head_r;
            case ({disp_acc_s, commit_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= IDX_ZERO;
            tail_r  <= IDX_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Entry storage: allocate at tail, fill from CDB, retire at head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                busy_r[i]    <= 1'b0;
                ready_r[i]   <= 1'b0;
                type_r[i]    <= 2'd0;
                rd_r[i]      <= {REG_BITS{1'b0}};
                value_r[i]   <= {XLEN{1'b0}};
                mispred_r[i] <= 1'b0;
                target_r[i]  <= {XLEN{1'b0}};
            end
        end else if (clear_s) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                busy_r[i] <= 1'b0;
            end
        end else begin
            if (disp_acc_s) begin
                busy_r[tail_r]    <= 1'b1;
                ready_r[tail_r]   <= 1'b0;
                type_r[tail_r]    <= disp_type;
                rd_r[tail_r]      <= disp_rd;
                mispred_r[tail_r] <= 1'b0;
            end
            if (wb_acc_s) begin
                ready_r[wb_rob_id]   <= 1'b1;
                value_r[wb_rob_id]   <= wb_value;
                mispred_r[wb_rob_id] <= wb_mispredict;
                target_r[wb_rob_id]  <= wb_target;
            end
            if (commit_s) begin
                busy_r[head_r] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued at dispatch
// and matched against the register/store commit ports.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, disp_valid, wb_valid, wb_mispredict;
    logic [1:0]  disp_type;
    logic [4:0]  disp_rd, disp_rob_id, wb_rob_id, set_dep_reg_id, set_dep_rob_id;
    logic [4:0]  set_value_reg_id, set_reg_rob_id, need_rob_id1, need_rob_id2, store_commit_rob_id;
    logic [31:0] wb_value, wb_target, set_val, rob_value1, rob_value2, clear_pc;
    logic        full, need_set_reg_dep, need_set_reg_value, rob_value1_ready, rob_value2_ready;
    logic        clear, store_commit;

    typedef struct packed {
        logic        st;
        logic [4:0]  id;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [4:0]  tail_m;

    reorder_buffer #(.ROB_BITS(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_rd(disp_rd),
        .full(full), .disp_rob_id(disp_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .need_set_reg_dep(need_set_reg_dep), .set_dep_reg_id(set_dep_reg_id),
        .set_dep_rob_id(set_dep_rob_id),
        .need_set_reg_value(need_set_reg_value), .set_value_reg_id(set_value_reg_id),
        .set_val(set_val), .set_reg_rob_id(set_reg_rob_id),
        .need_rob_id1(need_rob_id1), .need_rob_id2(need_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
        .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2),
        .clear(clear), .clear_pc(clear_pc),
        .store_commit(store_commit), .store_commit_rob_id(store_commit_rob_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; rdy = 1'b1; disp_valid = 1'b0; wb_valid = 1'b0;
        repeat (2) @(posedge clk);
        sb.delete();
        tail_m = 5'd0;
        #1;
        rst = 1'b1;
    endtask

    task automatic dispatch(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] val,
                            input bit exp_acc, input bit will_commit);
        disp_valid = 1'b1; disp_type = t; disp_rd = rd;
        #1;
        check_eq("disp_rob_id", disp_rob_id, tail_m);
        check_eq("need_set_reg_dep", need_set_reg_dep, exp_acc && t == 2'd0 && rd != 5'd0);
        if (exp_acc && need_set_reg_dep) check_eq("set_dep_rob_id", set_dep_rob_id, tail_m);
        if (exp_acc && will_commit && ((t == 2'd0 && rd != 5'd0) || t == 2'd2))
            sb.push_back('{st: (t == 2'd2), id: tail_m, rd: rd, val: val});
        cycle();
        disp_valid = 1'b0;
        if (exp_acc) tail_m = tail_m + 5'd1;
    endtask

    task automatic writeback(input logic [4:0] id, input logic [31:0] val,
                             input logic mis, input logic [31:0] tgt);
        wb_valid = 1'b1; wb_rob_id = id; wb_value = val; wb_mispredict = mis; wb_target = tgt;
        cycle();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
    endtask

    // Commit monitor: every observable commit must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst) begin
            if (need_set_reg_value || store_commit) begin
                check_eq("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("commit_kind", store_commit, e.st);
                    if (e.st) begin
                        check_eq("store_id", store_commit_rob_id, e.id);
                    end else begin
                        check_eq("commit_rd", set_value_reg_id, e.rd);
                        check_eq("commit_val", set_val, e.val);
                        check_eq("commit_id", set_reg_rob_id, e.id);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] v [32];
        rst = 1'b0; rdy = 1'b1; disp_valid = 1'b0; disp_type = 2'd0; disp_rd = 5'd0;
        wb_valid = 1'b0; wb_rob_id = 5'd0; wb_value = 32'd0; wb_mispredict = 1'b0;
        wb_target = 32'd0; need_rob_id1 = 5'd0; need_rob_id2 = 5'd0; tail_m = 5'd0;
        #2;
        check_eq("rst_full", full, 1'b0);
        check_eq("rst_disp_id", disp_rob_id, 5'd0);
        check_eq("rst_dep", need_set_reg_dep, 1'b0);
        check_eq("rst_setval", need_set_reg_value, 1'b0);
        check_eq("rst_clear", clear, 1'b0);
        check_eq("rst_clear_pc", clear_pc, 32'd0);
        check_eq("rst_store", store_commit, 1'b0);
        check_eq("rst_rv1", rob_value1_ready, 1'b0);
        check_eq("rst_rv2", rob_value2_ready, 1'b0);

        // Basic rename, writeback and commit
        do_reset();
        dispatch(2'd0, 5'd5, 32'h1234, 1'b1, 1'b1);
        writeback(5'd0, 32'h1234, 1'b0, 32'd0);
        check_eq("basic_commit", need_set_reg_value, 1'b1);
        check_eq("basic_rd", set_value_reg_id, 5'd5);
        check_eq("basic_val", set_val, 32'h1234);
        cycle();
        check_eq("basic_drain", sb.size(), 32'd0);

        // Fill to full, overflow attempt, then drain
        do_reset();
        for (int i = 0; i < 32; i++) begin
            v[i] = $urandom;
            dispatch(2'd0, 5'((i % 31) + 1), v[i], 1'b1, 1'b1);
        end
        check_eq("full_after_32", full, 1'b1);
        dispatch(2'd0, 5'd7, 32'd0, 1'b0, 1'b0);
        check_eq("tail_hold", disp_rob_id, 5'd0);
        check_eq("full_hold", full, 1'b1);
        writeback(5'd0, v[0], 1'b0, 32'd0);
        check_eq("full_at_commit", full, 1'b1);
        cycle();
        check_eq("full_after_commit", full, 1'b0);
        for (int i = 1; i < 32; i++) writeback(5'(i), v[i], 1'b0, 32'd0);
        repeat (2) cycle();
        check_eq("fill_drain", sb.size(), 32'd0);
        check_eq("fill_empty_full", full, 1'b0);

        // Out-of-order writeback, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v[i] = 32'hA000 + 32'(i);
            dispatch(2'd0, 5'(i + 1), v[i], 1'b1, 1'b1);
        end
        writeback(5'd2, v[2], 1'b0, 32'd0);
        check_eq("ooo_wait2", need_set_reg_value, 1'b0);
        writeback(5'd1, v[1], 1'b0, 32'd0);
        check_eq("ooo_wait1", need_set_reg_value, 1'b0);
        writeback(5'd0, v[0], 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check_eq("ooo_commit", need_set_reg_value, 1'b1);
            check_eq("ooo_order", set_reg_rob_id, 5'(k));
            cycle();
        end
        check_eq("ooo_done", need_set_reg_value, 1'b0);

        // Mispredicted branch flush
        do_reset();
        dispatch(2'd1, 5'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) dispatch(2'd0, 5'(i + 4), 32'd0, 1'b1, 1'b0);
        writeback(5'd1, 32'h55, 1'b0, 32'd0);
        writeback(5'd0, 32'd0, 1'b1, 32'h100);
        disp_valid = 1'b1; disp_type = 2'd0; disp_rd = 5'd9;
        #1;
        check_eq("flush_clear", clear, 1'b1);
        check_eq("flush_pc", clear_pc, 32'h100);
        check_eq("flush_no_dep", need_set_reg_dep, 1'b0);
        check_eq("flush_no_commit", need_set_reg_value, 1'b0);
        cycle();
        disp_valid = 1'b0; need_rob_id1 = 5'd1;
        #1;
        check_eq("flush_clear_off", clear, 1'b0);
        check_eq("flush_full", full, 1'b0);
        check_eq("flush_tail", disp_rob_id, 5'd0);
        check_eq("flush_lookup", rob_value1_ready, 1'b0);
        tail_m = 5'd0;

        // Bypass lookup and rdy freeze
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v[i] = (i == 4) ? 32'hAB : 32'hC00 + 32'(i);
            dispatch(2'd0, 5'(i + 1), v[i], 1'b1, 1'b1);
        end
        need_rob_id1 = 5'd4; need_rob_id2 = 5'd3;
        wb_valid = 1'b1; wb_rob_id = 5'd4; wb_value = 32'hAB;
        #1;
        check_eq("byp_ready", rob_value1_ready, 1'b1);
        check_eq("byp_val", rob_value1, 32'hAB);
        check_eq("byp_other_ready", rob_value2_ready, 1'b0);
        check_eq("byp_other_val", rob_value2, 32'd0);
        cycle();
        wb_valid = 1'b0;
        #1;
        check_eq("stored_ready", rob_value1_ready, 1'b1);
        check_eq("stored_val", rob_value1, 32'hAB);
        rdy = 1'b0; disp_valid = 1'b1; disp_rd = 5'd9;
        wb_valid = 1'b1; wb_rob_id = 5'd0; wb_value = 32'hDEAD;
        #1;
        check_eq("frz_dep", need_set_reg_dep, 1'b0);
        cycle();
        rdy = 1'b1; disp_valid = 1'b0; wb_valid = 1'b0; need_rob_id1 = 5'd0;
        #1;
        check_eq("frz_tail", disp_rob_id, 5'd5);
        check_eq("frz_wb", rob_value1_ready, 1'b0);
        writeback(5'd0, v[0], 1'b0, 32'd0);
        rdy = 1'b0;
        #1;
        check_eq("frz_commit", need_set_reg_value, 1'b0);
        cycle();
        check_eq("frz_commit_hold", need_set_reg_value, 1'b0);
        rdy = 1'b1;
        for (int i = 1; i < 4; i++) writeback(5'(i), v[i], 1'b0, 32'd0);
        repeat (3) cycle();
        check_eq("frz_drain", sb.size(), 32'd0);

        // Reset asserted with a commit pending
        do_reset();
        dispatch(2'd0, 5'd1, 32'h11, 1'b1, 1'b0);
        dispatch(2'd0, 5'd2, 32'h22, 1'b1, 1'b0);
        writeback(5'd0, 32'h11, 1'b0, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("midrst_commit", need_set_reg_value, 1'b0);
        check_eq("midrst_tail", disp_rob_id, 5'd0);
        check_eq("midrst_full", full, 1'b0);

        // Wrap-around with overlapping dispatch and commit
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] val;
            logic [1:0]  t;
            val = $urandom;
            t   = (i % 3 == 2) ? 2'd2 : 2'd0;
            dispatch(t, 5'((i % 31) + 1), val, 1'b1, 1'b1);
            writeback(5'(i % 32), val, 1'b0, 32'd0);
        end
        repeat (3) cycle();
        check_eq("wrap_drain", sb.size(), 32'd0);
        check_eq("wrap_tail", disp_rob_id, 5'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
